// File: rtl/data_memory_responder.sv
// Data memory responder for a single-cycle processor data port.
// Word RAM at 0x0000_0000, plus CYCLE / GPIO / STATUS registers at 0x8000_0000+.
// Optional feature macro: DMEM_CYCLE_COUNTER_EN (free-running 32-bit CYCLE counter).
module data_memory_responder #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic [31:0] gpio_out,
  output logic        err
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [DW-1:0] CYCLE_ADDR  = 32'h8000_0000;
  localparam logic [DW-1:0] GPIO_ADDR   = 32'h8000_0004;
  localparam logic [DW-1:0] STATUS_ADDR = 32'h8000_0008;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] gpio_q, gpio_d;
  logic          err_q, err_d;
  logic [DW-1:0] cycle_rd_c;

  logic          aligned_c;
  logic          is_ram_c;
  logic          is_cycle_c;
  logic          is_gpio_c;
  logic          is_status_c;
  logic          mapped_c;
  logic          ram_we_c;
  logic [AW-1:0] idx_c;

  // Address decode shared by the read mux and the write/err logic
  always_comb begin
    aligned_c   = (address_to_mem[1:0] == 2'b00);
    is_ram_c    = (address_to_mem[DW-1:AW+2] == '0);
    is_cycle_c  = (address_to_mem == CYCLE_ADDR);
    is_gpio_c   = (address_to_mem == GPIO_ADDR);
    is_status_c = (address_to_mem == STATUS_ADDR);
    mapped_c    = is_ram_c | is_cycle_c | is_gpio_c | is_status_c;
    idx_c       = address_to_mem[AW+1:2];
    ram_we_c    = WE & aligned_c & is_ram_c;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [DW-1:0] cycle_q, cycle_d;

  // Free-running cycle count, wraps naturally at 2^32
  always_comb begin
    cycle_d = cycle_q + DW'(1);
  end

  // Counter register, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_d;
  end

  assign cycle_rd_c = cycle_q;
`else
  assign cycle_rd_c = '0;
`endif

  // Combinational read mux; misaligned and unmapped reads return zero
  always_comb begin
    data_from_mem = '0;
    if (aligned_c) begin
      if (is_ram_c)         data_from_mem = mem_q[idx_c];
      else if (is_cycle_c)  data_from_mem = cycle_rd_c;
      else if (is_gpio_c)   data_from_mem = gpio_q;
      else if (is_status_c) data_from_mem = {(DW-1)'(0), err_q};
    end
  end

  // Next-state for GPIO and the sticky error flag; setting wins over clearing
  always_comb begin
    gpio_d = gpio_q;
    err_d  = err_q;
    if (WE && aligned_c && is_gpio_c) gpio_d = data_to_mem;
    if (WE && aligned_c && is_status_c && data_to_mem[0]) err_d = 1'b0;
    if (WE && (!aligned_c || !mapped_c)) err_d = 1'b1;
  end

  // Control registers, cleared asynchronously so writes during reset are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q <= '0;
      err_q  <= 1'b0;
    end else begin
      gpio_q <= gpio_d;
      err_q  <= err_d;
    end
  end

  // RAM array is outside the reset domain so stores still land during reset
  always_ff @(posedge clk) begin
    if (ram_we_c) mem_q[idx_c] <= data_to_mem;
  end

  assign gpio_out = gpio_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder; the default build expects CYCLE to read 0,
// while a DMEM_CYCLE_COUNTER_EN build expects a live counter.
module tb_data_memory_responder;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] gpio_out;
  logic        err;

  int vectors;
  int miscompares;

  data_memory_responder #(.DEPTH(64)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .WE             (we),
    .address_to_mem (addr),
    .data_to_mem    (wdata),
    .data_from_mem  (rdata),
    .gpio_out       (gpio_out),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one write cycle; returns at the negedge after the capturing posedge
  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (gpio_out !== 32'h0) begin
      miscompares++; $display("FAIL reset_gpio: got %h want %h", gpio_out, 32'h0);
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL reset_err: got %b want %b", err, 1'b0);
    end
    addr = 32'h8000_0000;
    #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_cycle: got %h want %h", rdata, 32'h0);
    end
    // writes during reset: RAM takes it, GPIO drops it
    write_word(32'h0000_0020, 32'h1234_5678);
    write_word(32'h8000_0004, 32'h0000_0055);
    #1;
    vectors++;
    if (gpio_out !== 32'h0) begin
      miscompares++; $display("FAIL reset_gpio_wr_dropped: got %h want %h", gpio_out, 32'h0);
    end
    addr = 32'h0000_0020;
    #1;
    vectors++;
    if (rdata !== 32'h1234_5678) begin
      miscompares++; $display("FAIL reset_ram_wr_kept: got %h want %h", rdata, 32'h1234_5678);
    end
  endtask

  task automatic test_counter_release();
    logic [31:0] exp5;
`ifdef DMEM_CYCLE_COUNTER_EN
    exp5 = 32'd5;
`else
    exp5 = 32'd0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    addr = 32'h8000_0000;
    #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++; $display("FAIL cycle_first: got %h want %h", rdata, 32'h0);
    end
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if (rdata !== exp5) begin
      miscompares++; $display("FAIL cycle_after5: got %h want %h", rdata, exp5);
    end
  endtask

  task automatic test_ram_roundtrip();
    write_word(32'h0000_0010, 32'h1111_1111);
    @(negedge clk);
    we = 1'b1; addr = 32'h0000_0010; wdata = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if (rdata !== 32'h1111_1111) begin
      miscompares++; $display("FAIL ram_same_cycle_old: got %h want %h", rdata, 32'h1111_1111);
    end
    @(negedge clk);
    we = 1'b0;
    #1;
    vectors++;
    if (rdata !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL ram_roundtrip: got %h want %h", rdata, 32'hDEAD_BEEF);
    end
    addr = 32'h0000_0020;
    #1;
    vectors++;
    if (rdata !== 32'h1234_5678) begin
      miscompares++; $display("FAIL ram_other_word: got %h want %h", rdata, 32'h1234_5678);
    end
  endtask

  task automatic test_misaligned();
    write_word(32'h0000_0004, 32'hCAFE_F00D);
    addr = 32'h0000_0005;
    #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++; $display("FAIL misaligned_read: got %h want %h", rdata, 32'h0);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL misaligned_read_no_err: got %b want %b", err, 1'b0);
    end
    write_word(32'h0000_0006, 32'hFFFF_FFFF);
    #1;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++; $display("FAIL misaligned_write_err: got %b want %b", err, 1'b1);
    end
    addr = 32'h0000_0004;
    #1;
    vectors++;
    if (rdata !== 32'hCAFE_F00D) begin
      miscompares++; $display("FAIL misaligned_ram_unchanged: got %h want %h", rdata, 32'hCAFE_F00D);
    end
  endtask

  task automatic test_err_clear();
    addr = 32'h8000_0008;
    #1;
    vectors++;
    if (rdata !== 32'h1) begin
      miscompares++; $display("FAIL status_read: got %h want %h", rdata, 32'h1);
    end
    write_word(32'h8000_0008, 32'h0000_0002);
    #1;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++; $display("FAIL status_bit1_ignored: got %b want %b", err, 1'b1);
    end
    write_word(32'h8000_0008, 32'h0000_0001);
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL status_clear: got %b want %b", err, 1'b0);
    end
  endtask

  task automatic test_unmapped();
    addr = 32'h4000_0000;
    #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++; $display("FAIL unmapped_read: got %h want %h", rdata, 32'h0);
    end
    addr = 32'h0000_0100;
    #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++; $display("FAIL above_ram_read: got %h want %h", rdata, 32'h0);
    end
    write_word(32'h4000_0000, 32'h0BAD_0BAD);
    #1;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++; $display("FAIL unmapped_write_err: got %b want %b", err, 1'b1);
    end
    write_word(32'h8000_0008, 32'h0000_0001);
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL unmapped_clear: got %b want %b", err, 1'b0);
    end
  endtask

  task automatic test_cycle_write();
    write_word(32'h8000_0000, 32'h7777_7777);
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL cycle_write_no_err: got %b want %b", err, 1'b0);
    end
    addr = 32'h8000_0000;
    #1;
    vectors++;
    if (rdata === 32'h7777_7777) begin
      miscompares++; $display("FAIL cycle_write_ignored: got %h want not %h", rdata, 32'h7777_7777);
    end
  endtask

  task automatic test_gpio_reset();
    write_word(32'h8000_0004, 32'h0000_00A5);
    #1;
    vectors++;
    if (gpio_out !== 32'h0000_00A5) begin
      miscompares++; $display("FAIL gpio_write: got %h want %h", gpio_out, 32'h0000_00A5);
    end
    addr = 32'h8000_0004;
    #1;
    vectors++;
    if (rdata !== 32'h0000_00A5) begin
      miscompares++; $display("FAIL gpio_readback: got %h want %h", rdata, 32'h0000_00A5);
    end
    write_word(32'h4000_0000, 32'h0);
    addr = 32'h0000_0010;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (gpio_out !== 32'h0) begin
      miscompares++; $display("FAIL gpio_async_reset: got %h want %h", gpio_out, 32'h0);
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL err_async_reset: got %b want %b", err, 1'b0);
    end
    vectors++;
    if (rdata !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL ram_survives_reset: got %h want %h", rdata, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef DMEM_CYCLE_COUNTER_EN
  task automatic test_cycle_wrap();
    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    addr = 32'h8000_0000;
    #1;
    vectors++;
    if (rdata !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL cycle_preset: got %h want %h", rdata, 32'hFFFF_FFFF);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++; $display("FAIL cycle_wrap: got %h want %h", rdata, 32'h0);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    we = 1'b0;
    addr = 32'h0;
    wdata = 32'h0;
    test_reset();
    test_counter_release();
    test_ram_roundtrip();
    test_misaligned();
    test_err_clear();
    test_unmapped();
    test_cycle_write();
    test_gpio_reset();
`ifdef DMEM_CYCLE_COUNTER_EN
    test_cycle_wrap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, giving the number of 32-bit RAM words (power of two, 4..1024).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port WE, input, 1 bit: write enable from the processor data port.
REQ-005 The module SHALL have port address_to_mem, input, 32 bits: byte address from the processor.
REQ-006 The module SHALL have port data_to_mem, input, 32 bits: store data.
REQ-007 The module SHALL have port data_from_mem, output, 32 bits: load data, returned combinationally.
REQ-008 The module SHALL have port gpio_out, output, 32 bits: the memory-mapped output register.
REQ-009 The module SHALL have port err, output, 1 bit: the sticky access-error flag.

Function
REQ-010 Address map: RAM at 0x0000_0000 to DEPTH*4-1; CYCLE at 0x8000_0000 (read-only); GPIO at 0x8000_0004 (read/write); STATUS at 0x8000_0008 (bit0 = err, write-1-to-clear).
REQ-011 Reads SHALL be combinational from address_to_mem, with zero latency within the same cycle, as the single-cycle processor requires.
REQ-012 A write SHALL take effect at the rising clk edge where WE=1; the new value is readable from the next cycle.
REQ-013 A read and a write to the same word in the same cycle SHALL return the old data.
REQ-014 A RAM access SHALL index RAM with address_to_mem[log2(DEPTH)+1:2].
REQ-015 Misaligned access (address_to_mem[1:0]!=0) with WE=1 SHALL be ignored and SHALL set err.
REQ-016 Misaligned reads SHALL return 0 and SHALL NOT set err, because the address is combinationally undefined for non-memory instructions.
REQ-017 An unmapped address SHALL read 0.
REQ-018 An unmapped address with WE=1 SHALL be ignored and SHALL set err.
REQ-019 A write to CYCLE SHALL be ignored without setting err.
REQ-020 The CYCLE counter SHALL increment by 1 every clk edge while out of reset and SHALL wrap 0xFFFF_FFFF to 0.
REQ-021 A read of CYCLE SHALL return the pre-edge count.
REQ-022 A write to STATUS with data_to_mem[0]=1 SHALL clear err; other STATUS bits SHALL be ignored.
REQ-023 If an error-setting event and a clear occur in the same cycle, set SHALL win; this applies only via future map extensions, since a STATUS write is itself mapped.
REQ-024 gpio_out SHALL reflect the GPIO register directly, registered with no combinational path from inputs.

Reset
REQ-025 While reset=0: CYCLE=0, GPIO=0 (gpio_out=0), err=0, asynchronously and independent of clk.
REQ-026 RAM contents SHALL NOT be cleared by reset.
REQ-027 data_from_mem SHALL remain a pure function of address and RAM during reset.
REQ-028 A write asserted during reset SHALL be dropped for GPIO and STATUS.
REQ-029 A write asserted during reset SHALL still update RAM.
REQ-030 On reset release, CYCLE SHALL read 0 in the first cycle and 1 after the first rising edge.

Configuration
REQ-031 Macro DMEM_CYCLE_COUNTER_EN SHALL control the cycle counter.
REQ-032 When DMEM_CYCLE_COUNTER_EN is defined, the 32-bit CYCLE counter SHALL be implemented as specified.
REQ-033 When DMEM_CYCLE_COUNTER_EN is undefined, no counter flops SHALL exist.
REQ-034 When DMEM_CYCLE_COUNTER_EN is undefined, 0x8000_0000 SHALL read 0 and writes to it SHALL be ignored without err.

Verification
REQ-035 RAM round trip: write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 next cycle -> 0xDEAD_BEEF; same-cycle read during write -> prior value.
REQ-036 Error path: WE=1 at 0x0000_0006 -> RAM unchanged, err=1 after edge.
REQ-037 Error clear: then write 0x1 to 0x8000_0008 -> err=0.
REQ-038 Unmapped write: write to 0x4000_0000 -> err=1.
REQ-039 Unmapped read: read 0x4000_0000 -> 0.
REQ-040 GPIO/reset: write 0x0000_00A5 to 0x8000_0004 -> gpio_out=0xA5 next cycle; pulse reset low mid-cycle -> gpio_out=0 immediately, RAM word 0x10 still 0xDEAD_BEEF.
REQ-041 Counter: release reset, read CYCLE after 5 edges -> 5; force counter to 0xFFFF_FFFF -> 0 after next edge; rebuild without DMEM_CYCLE_COUNTER_EN -> reads 0.
